// File: rtl/clint_timer_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart msip/mtimecmp.
// Optional CLINT_MTIME_LATCH_EN: LO read snapshots HI for coherent pairs.
module clint_timer_mh #(
  parameter int NUM_HARTS  = 2,
  parameter int PRESCALE_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 reg_en_i,
  input  logic [31:0]          reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic                 reg_we_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_ready_o,
  output logic [NUM_HARTS-1:0] irq_software_o,
  output logic [NUM_HARTS-1:0] irq_timer_o,
  output logic [63:0]          mtime_o
);

  localparam logic [6:0] OFF_CTRL = 7'h7C;
  localparam logic [6:0] OFF_MTLO = 7'h7E;
  localparam logic [6:0] OFF_MTHI = 7'h7F;

  logic [6:0] off;
  logic [3:0] hsel;
  logic       msip_hit;
  logic       cmp_hit;
  logic       wr;
  logic       rd;
  logic       unused_addr;

  assign off         = reg_addr_i[8:2];
  assign msip_hit    = (off[6:4] == 3'b000);
  assign cmp_hit     = (off[6:5] == 2'b10);
  assign hsel        = msip_hit ? off[3:0] : off[4:1];
  assign wr          = reg_en_i & reg_we_i;
  assign rd          = reg_en_i & ~reg_we_i;
  assign unused_addr = ^{reg_addr_i[31:9], reg_addr_i[1:0]};

  logic                  en_q;
  logic [PRESCALE_W-1:0] div_q;
  logic [PRESCALE_W-1:0] pcnt_q;
  logic [63:0]           mtime_q;
  logic [63:0]           mt_nxt;
  logic [NUM_HARTS-1:0]  msip_q;
  logic [63:0]           cmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0]  irq_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_val;
  logic [31:0]           ctrl_rd;
  logic [31:0]           mt_hi_rd;
  logic                  tick;

  logic [NUM_HARTS-1:0]  msip_we;
  logic [NUM_HARTS-1:0]  cmplo_we;
  logic [NUM_HARTS-1:0]  cmphi_we;
  logic                  ctrl_we;
  logic                  mtlo_we;
  logic                  mthi_we;

  assign ctrl_we = wr & (off == OFF_CTRL);
  assign mtlo_we = wr & (off == OFF_MTLO);
  assign mthi_we = wr & (off == OFF_MTHI);

  // Hart indices past NUM_HARTS simply match no strobe.
  always_comb begin
    msip_we  = '0;
    cmplo_we = '0;
    cmphi_we = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hsel == 4'(h)) begin
        msip_we[h]  = wr & msip_hit;
        cmplo_we[h] = wr & cmp_hit & ~off[0];
        cmphi_we[h] = wr & cmp_hit & off[0];
      end
    end
  end

  assign tick = en_q & (pcnt_q == div_q);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      en_q   <= 1'b1;
      div_q  <= '0;
      pcnt_q <= '0;
    end else begin
      if (ctrl_we) begin
        en_q  <= reg_wdata_i[0];
        div_q <= reg_wdata_i[8 +: PRESCALE_W];
      end
      if (ctrl_we || tick) begin
        pcnt_q <= '0;
      end else if (en_q) begin
        pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end

  // A LO write suppresses the carry; a HI write keeps the LO increment.
  always_comb begin
    mt_nxt = mtime_q;
    if (tick) begin
      mt_nxt = mtime_q + 64'd1;
    end
    if (mtlo_we) begin
      mt_nxt = {mtime_q[63:32], reg_wdata_i};
    end
    if (mthi_we) begin
      mt_nxt[63:32] = reg_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mtime_q <= '0;
    end else begin
      mtime_q <= mt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      msip_q <= '0;
      irq_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        cmp_q[h] <= '1;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (msip_we[h]) begin
          msip_q[h] <= reg_wdata_i[0];
        end
        if (cmplo_we[h]) begin
          cmp_q[h][31:0] <= reg_wdata_i;
        end
        if (cmphi_we[h]) begin
          cmp_q[h][63:32] <= reg_wdata_i;
        end
        irq_q[h] <= (mtime_q >= cmp_q[h]);
      end
    end
  end

`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] shadow_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      shadow_q <= '0;
    end else if (rd && (off == OFF_MTLO)) begin
      shadow_q <= mtime_q[63:32];
    end
  end

  assign mt_hi_rd = shadow_q;
`else
  assign mt_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[0]                = en_q;
    ctrl_rd[8 +: PRESCALE_W]  = div_q;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      msip_hit: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (hsel == 4'(h)) begin
            rd_val = {31'd0, msip_q[h]};
          end
        end
      end
      cmp_hit: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (hsel == 4'(h)) begin
            rd_val = off[0] ? cmp_q[h][63:32]
                            : cmp_q[h][31:0];
          end
        end
      end
      (off == OFF_CTRL): rd_val = ctrl_rd;
      (off == OFF_MTLO): rd_val = mtime_q[31:0];
      (off == OFF_MTHI): rd_val = mt_hi_rd;
      default:           rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
    end else if (rd) begin
      rdata_q <= rd_val;
    end
  end

  assign reg_rdata_o    = rdata_q;
  assign reg_ready_o    = 1'b1;
  assign irq_software_o = msip_q;
  assign irq_timer_o    = irq_q;
  assign mtime_o        = mtime_q;

endmodule

// File: tb/tb_clint_timer_mh.sv
// Directed bench for clint_timer_mh: register table plus timing sequences.
// Build with CLINT_MTIME_LATCH_EN to exercise the coherent HI read.
module tb_clint_timer_mh;

  logic        clk;
  logic        rstn;
  logic        reg_en;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic [1:0]  irq_sw;
  logic [1:0]  irq_tmr;
  logic [63:0] mtime;

  int checks = 0;
  int errors = 0;

  clint_timer_mh #(
    .NUM_HARTS  (2),
    .PRESCALE_W (8)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .reg_en_i       (reg_en),
    .reg_addr_i     (reg_addr),
    .reg_wdata_i    (reg_wdata),
    .reg_we_i       (reg_we),
    .reg_rdata_o    (reg_rdata),
    .reg_ready_o    (reg_ready),
    .irq_software_o (irq_sw),
    .irq_timer_o    (irq_tmr),
    .mtime_o        (mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    reg_en    = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    reg_en = 1'b0;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    reg_en   = 1'b1;
    reg_we   = 1'b0;
    reg_addr = a;
    @(negedge clk);
    reg_en = 1'b0;
    d      = reg_rdata;
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  logic [31:0] r;
  logic [31:0] a0;
  logic [31:0] b0;
  int          drops;

  initial begin
    tv[0]  = '{0, 32'h0000_01F0, 32'h0000_0000, "stop"};
    tv[1]  = '{0, 32'h0000_01F8, 32'h1234_5678, "w_mtlo"};
    tv[2]  = '{0, 32'h0000_01FC, 32'hDEAD_BEEF, "w_mthi"};
    tv[3]  = '{1, 32'h0000_01F8, 32'h1234_5678, "mt_lo"};
    tv[4]  = '{1, 32'h0000_01FC, 32'hDEAD_BEEF, "mt_hi"};
    tv[5]  = '{2, 32'h0000_0000, 32'hDEAD_BEEF, "rd_hold"};
    tv[6]  = '{1, 32'h0000_01F0, 32'h0000_0000, "ctrl_rd0"};
    tv[7]  = '{0, 32'h0000_01F0, 32'hFFFF_FFFE, "w_ctrl_ff"};
    tv[8]  = '{1, 32'h0000_01F0, 32'h0000_FF00, "ctrl_div"};
    tv[9]  = '{0, 32'h0000_01F0, 32'h0000_0500, "w_ctrl5"};
    tv[10] = '{1, 32'h0000_01F0, 32'h0000_0500, "ctrl_div5"};
    tv[11] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, "w_msip0"};
    tv[12] = '{1, 32'h0000_0000, 32'h0000_0001, "msip_rd"};
    tv[13] = '{0, 32'h0000_0000, 32'h0000_0000, "w_msip0c"};
    tv[14] = '{1, 32'h0000_0000, 32'h0000_0000, "msip_clr"};
    tv[15] = '{0, 32'h0000_003C, 32'h0000_0001, "w_msipbad"};
    tv[16] = '{1, 32'h0000_003C, 32'h0000_0000, "msip_bad"};
    tv[17] = '{0, 32'h0000_0100, 32'hAAAA_5555, "w_cmp0lo"};
    tv[18] = '{1, 32'h0000_0100, 32'hAAAA_5555, "cmp0_lo"};
    tv[19] = '{0, 32'h0000_010C, 32'h1234_5678, "w_cmp1hi"};
    tv[20] = '{1, 32'h0000_010C, 32'h1234_5678, "cmp1_hi"};
    tv[21] = '{1, 32'h0000_0104, 32'hFFFF_FFFF, "cmp0_hi_rst"};
    tv[22] = '{0, 32'h0000_0110, 32'h0000_0005, "w_cmpbad"};
    tv[23] = '{1, 32'h0000_0110, 32'h0000_0000, "cmp_bad"};
    tv[24] = '{1, 32'h0000_01F4, 32'h0000_0000, "unmap_7d"};
    tv[25] = '{1, 32'h0000_0080, 32'h0000_0000, "unmap_20"};
    tv[26] = '{1, 32'h1000_01F8, 32'h1234_5678, "addr_hi_ign"};
    tv[27] = '{1, 32'h0000_01FC, 32'hDEAD_BEEF, "mt_hi2"};

    rstn      = 1'b0;
    reg_en    = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_irq_tmr", 64'(irq_tmr), 64'd0);
    chk("rst_irq_sw", 64'(irq_sw), 64'd0);
    chk("rst_mtime", mtime, 64'd0);
    chk("rst_rdata", 64'(reg_rdata), 64'd0);
    chk("ready", 64'(reg_ready), 64'd1);
    rstn = 1'b1;

    rd(32'h0000_0108, r);
    chk("rst_cmp1_lo", 64'(r), 64'hFFFF_FFFF);
    chk("rst_no_tmr", 64'(irq_tmr), 64'd0);
    repeat (7) @(negedge clk);
    rd(32'h0000_01F8, r);
    checks++;
    if (r < 32'd8 || r > 32'd12) begin
      errors++;
      $display("FAIL free_run: got %h expected 0000000a +/-2", r);
    end

    for (int i = 0; i < NV; i++) begin
      case (tv[i].op)
        0: wr(tv[i].addr, tv[i].data);
        1: begin
          rd(tv[i].addr, r);
          chk(tv[i].name, 64'(r), 64'(tv[i].data));
        end
        default: begin
          @(negedge clk);
          chk(tv[i].name, 64'(reg_rdata), 64'(tv[i].data));
        end
      endcase
    end

    // Prescaler DIV=3: one tick per 4 cycles
    wr(32'h0000_01FC, 32'h0);
    wr(32'h0000_01F8, 32'h0);
    wr(32'h0000_01F0, 32'h0000_0301);
    rd(32'h0000_01F8, a0);
    repeat (38) @(negedge clk);
    rd(32'h0000_01F8, b0);
    chk("div3_delta", 64'(b0 - a0), 64'd10);
    wr(32'h0000_01F0, 32'h0);
    rd(32'h0000_01F8, a0);
    repeat (18) @(negedge clk);
    rd(32'h0000_01F8, b0);
    chk("frozen", 64'(b0 - a0), 64'd0);

    // Carry from LO into HI
    wr(32'h0000_01FC, 32'h0);
    wr(32'h0000_01F8, 32'hFFFF_FFFE);
    wr(32'h0000_01F0, 32'h0000_0001);
    chk("carry0", mtime, 64'h0000_0000_FFFF_FFFE);
    @(negedge clk);
    chk("carry1", mtime, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    chk("carry2", mtime, 64'h0000_0001_0000_0000);

    // Full 64-bit wrap
    wr(32'h0000_01F0, 32'h0);
    wr(32'h0000_01FC, 32'hFFFF_FFFF);
    wr(32'h0000_01F8, 32'hFFFF_FFFF);
    chk("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(32'h0000_01F0, 32'h0000_0001);
    @(negedge clk);
    chk("wrap", mtime, 64'h0);

    // Writes landing on tick cycles
    wr(32'h0000_01F0, 32'h0);
    wr(32'h0000_01FC, 32'h0000_0005);
    wr(32'h0000_01F8, 32'hFFFF_FFFE);
    wr(32'h0000_01F0, 32'h0000_0001);
    wr(32'h0000_01F8, 32'h0000_0010);
    chk("lo_wr_nocarry", mtime, 64'h0000_0005_0000_0010);
    wr(32'h0000_01FC, 32'h0000_0007);
    chk("hi_wr_loinc", mtime, 64'h0000_0007_0000_0012);

    // Timer interrupts
    wr(32'h0000_01F0, 32'h0);
    wr(32'h0000_01FC, 32'h0);
    wr(32'h0000_01F8, 32'h0000_00F0);
    wr(32'h0000_0104, 32'hFFFF_FFFF);
    wr(32'h0000_0100, 32'h0000_0100);
    wr(32'h0000_0104, 32'h0);
    wr(32'h0000_010C, 32'hFFFF_FFFF);
    wr(32'h0000_0108, 32'h0000_0200);
    wr(32'h0000_010C, 32'h0);
    @(negedge clk);
    chk("tmr_idle", 64'(irq_tmr), 64'd0);
    wr(32'h0000_01F0, 32'h0000_0001);
    repeat (16) @(negedge clk);
    chk("mt_at_100", mtime, 64'h100);
    chk("tmr_pre0", 64'(irq_tmr), 64'd0);
    @(negedge clk);
    chk("tmr0_rise", 64'(irq_tmr), 64'b01);
    repeat (255) @(negedge clk);
    chk("mt_at_200", mtime, 64'h200);
    chk("tmr_pre1", 64'(irq_tmr), 64'b01);
    @(negedge clk);
    chk("tmr1_rise", 64'(irq_tmr), 64'b11);
    wr(32'h0000_0104, 32'hFFFF_FFFF);
    chk("tmr0_lag", 64'(irq_tmr), 64'b11);
    @(negedge clk);
    chk("tmr0_drop", 64'(irq_tmr), 64'b10);
    wr(32'h0000_0100, 32'hFFFF_FFFF);
    wr(32'h0000_010C, 32'hFFFF_FFFF);
    wr(32'h0000_0108, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("tmr_all_drop", 64'(irq_tmr), 64'd0);

    // Software interrupt
    wr(32'h0000_0004, 32'h0000_0001);
    chk("msip1_set", 64'(irq_sw), 64'b10);
    drops = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (irq_sw !== 2'b10) drops++;
    end
    chk("msip1_hold", 64'(drops), 64'd0);
    wr(32'h0000_0004, 32'h0);
    chk("msip1_clr", 64'(irq_sw), 64'd0);
    rd(32'h0000_003C, r);
    chk("off0f_rd", 64'(r), 64'd0);

    // LO then HI read across a HI rollover
    wr(32'h0000_01F0, 32'h0);
    wr(32'h0000_01FC, 32'h0000_0001);
    wr(32'h0000_01F8, 32'hFFFF_FFF0);
    wr(32'h0000_01F0, 32'h0000_0001);
    rd(32'h0000_01F8, r);
    chk("pair_lo", 64'(r), 64'hFFFF_FFF1);
    repeat (32) @(negedge clk);
    rd(32'h0000_01FC, r);
`ifdef CLINT_MTIME_LATCH_EN
    chk("pair_hi", 64'(r), 64'h1);
`else
    chk("pair_hi", 64'(r), 64'h2);
`endif

    // Reset wins over a concurrent write
    wr(32'h0000_0004, 32'h0000_0001);
    wr(32'h0000_0104, 32'h0);
    @(negedge clk);
    rstn      = 1'b0;
    reg_en    = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = 32'h0000_0000;
    reg_wdata = 32'h0000_0001;
    @(negedge clk);
    reg_en = 1'b0;
    reg_we = 1'b0;
    chk("mrst_mtime", mtime, 64'd0);
    chk("mrst_sw", 64'(irq_sw), 64'd0);
    chk("mrst_tmr", 64'(irq_tmr), 64'd0);
    chk("mrst_rdata", 64'(reg_rdata), 64'd0);
    rstn = 1'b1;
    rd(32'h0000_01F0, r);
    chk("mrst_ctrl", 64'(r), 64'h1);
    rd(32'h0000_0104, r);
    chk("mrst_cmp0hi", 64'(r), 64'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
